// File: rtl/pending_encoder.sv
// Sequential N-to-log2(N) priority encoder: captures rising request edges into a pending
// register and presents the highest-index pending request with a valid/ack handshake.
module pending_encoder #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [N-1:0] i_y,
    input  logic         i_ack,
    output logic [W-1:0] o_w,
    output logic         o_valid,
    output logic [N-1:0] o_pending,
    output logic         o_ovf
);

    typedef enum logic {StIdle, StHold} state_e;

    state_e       r_state;
    logic [N-1:0] r_y_q;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_w;
    logic         r_valid;
    logic         r_ovf;

    logic [N-1:0] w_event;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pending_d;
    logic         w_ovf_hit;
    logic [W-1:0] w_top_idx;

    assign w_event = i_y & ~r_y_q & {N{i_en}};

    always_comb begin
        w_clr = '0;
        if (r_state == StHold && i_ack) begin
            w_clr = {{(N-1){1'b0}}, 1'b1} << r_w;
        end
    end

    // A bit being freed this cycle may be re-set without counting as an overflow.
    assign w_ovf_hit   = |(w_event & r_pending & ~w_clr);
    assign w_pending_d = (r_pending & ~w_clr) | w_event;

    always_comb begin
        w_top_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_pending[i]) begin
                w_top_idx = W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_y_q     <= '0;
            r_pending <= '0;
            r_w       <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_y_q     <= i_y;
            r_pending <= w_pending_d;
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (|r_pending) begin
                        r_w     <= w_top_idx;
                        r_valid <= 1'b1;
                        r_state <= StHold;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                StHold: begin
                    if (i_ack) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_w       = r_w;
    assign o_valid   = r_valid;
    assign o_pending = r_pending;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_pending_encoder.sv
// Directed bench for pending_encoder: expected grant codes are queued when requests are
// driven and popped when the DUT presents a valid code.
module tb_pending_encoder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] y;
    logic         ack;
    logic [W-1:0] w;
    logic         valid;
    logic [N-1:0] pending;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    pending_encoder #(.N(N), .W(W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_y       (y),
        .i_ack     (ack),
        .o_w       (w),
        .o_valid   (valid),
        .o_pending (pending),
        .o_ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a presented code and compare it to the oldest queued expectation.
    task automatic wait_grant(input string tag);
        logic [W-1:0] exp_w;
        for (int i = 0; i < 10 && !valid; i++) tick();
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            exp_w = exp_q.pop_front();
            chk({tag, "_w"}, 32'(w), 32'(exp_w));
        end
    endtask

    task automatic pulse(input logic [N-1:0] v);
        y = v;
        tick();
        y = '0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        y     = '0;
        ack   = 1'b0;
        tick();
        tick();
        chk("rst_w", 32'(w), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        tick();

        // Single request: 2-cycle latency, then ack clears it.
        en = 1'b1;
        pulse(4'b0100);
        chk("t1_pending", 32'(pending), 32'b0100);
        chk("t1_valid_early", 32'(valid), 0);
        exp_q.push_back(2'd2);
        tick();
        wait_grant("t1");
        do_ack();
        chk("t1_ack_valid", 32'(valid), 0);
        chk("t1_ack_pending", 32'(pending), 0);

        // Disabled capture, then enabling while the line is already high.
        en = 1'b0;
        pulse(4'b0010);
        tick();
        chk("t2_dis_pending", 32'(pending), 0);
        chk("t2_dis_valid", 32'(valid), 0);
        y = 4'b0010;
        tick();
        en = 1'b1;
        tick();
        tick();
        chk("t2_held_pending", 32'(pending), 0);
        chk("t2_held_valid", 32'(valid), 0);
        y = '0;
        tick();

        // Multi-hot: served highest index first with one-cycle bubbles.
        pulse(4'b1011);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        wait_grant("t3a");
        do_ack();
        chk("t3_bubble_valid", 32'(valid), 0);
        chk("t3_after_ack_pending", 32'(pending), 32'b0011);
        tick();
        wait_grant("t3b");
        do_ack();
        wait_grant("t3c");
        do_ack();
        chk("t3_ovf", 32'(ovf), 0);
        chk("t3_pending", 32'(pending), 0);

        // No preemption while holding.
        pulse(4'b0011);
        exp_q.push_back(2'd1);
        wait_grant("t4a");
        pulse(4'b1000);
        tick();
        tick();
        chk("t4_hold_w", 32'(w), 1);
        chk("t4_hold_valid", 32'(valid), 1);
        chk("t4_hold_pending", 32'(pending), 32'b1011);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        do_ack();
        wait_grant("t4b");
        do_ack();
        wait_grant("t4c");
        do_ack();

        // Same-cycle set and ack on the presented bit: set wins, no overflow.
        pulse(4'b0100);
        exp_q.push_back(2'd2);
        wait_grant("t5a");
        ack = 1'b1;
        y   = 4'b0100;
        tick();
        ack = 1'b0;
        y   = '0;
        chk("t5_setwin_pending", 32'(pending), 32'b0100);
        chk("t5_setwin_ovf", 32'(ovf), 0);
        exp_q.push_back(2'd2);
        wait_grant("t5b");
        do_ack();
        chk("t5_pending_clear", 32'(pending), 0);

        // Double event on a pending bit raises sticky overflow.
        pulse(4'b0100);
        tick();
        pulse(4'b0100);
        chk("t6_ovf_set", 32'(ovf), 1);
        exp_q.push_back(2'd2);
        wait_grant("t6");
        do_ack();
        tick();
        chk("t6_ovf_sticky", 32'(ovf), 1);
        chk("t6_pending", 32'(pending), 0);

        // Asynchronous reset mid-hold, with a line held high through reset.
        pulse(4'b1000);
        exp_q.push_back(2'd3);
        wait_grant("t7a");
        y = 4'b0010;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_valid", 32'(valid), 0);
        chk("t7_async_w", 32'(w), 0);
        chk("t7_async_pending", 32'(pending), 0);
        chk("t7_async_ovf", 32'(ovf), 0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        y = '0;
        chk("t7_held_event", 32'(pending), 32'b0010);
        // Ack while nothing is presented must be ignored.
        exp_q.push_back(2'd1);
        do_ack();
        chk("t7_ign_ack_pending", 32'(pending), 32'b0010);
        wait_grant("t7b");
        do_ack();
        do_ack();
        chk("t7_final_pending", 32'(pending), 0);
        chk("t7_final_valid", 32'(valid), 0);
        chk("t7_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
